aw_sram_loader: RTL and testbench
=================================

# aw_sram_loader

Host-side writer that fills the activation (ACT) and weight (W) SRAMs that the corelet reads, then hands control to the corelet. It accepts a valid/ready word stream of one tile: 36 activation words, then 72 weight words (9 kij × 8 rows, kij-major). It pulses `seq_begin`, waits for `seq_done` under a watchdog, and reports completion. It sits between the testbench/host and the SRAM port muxes in front of the corelet.

## Interface

Parameters:
- `ACT_WORDS`, 36: activation words per tile, written to ACT addresses 0..ACT_WORDS-1.
- `W_WORDS`, 72: weight words per tile, written to W addresses 0..W_WORDS-1.
- `ADDR_W`, 7: SRAM address width.
- `DATA_W`, 32: SRAM word width (8 × 4-bit).
- `TIMEOUT`, 4095: maximum cycles spent waiting for `seq_done`.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `load_start` in 1: one-cycle request to load a tile; honoured only in IDLE.
- `in_valid` in 1: host word valid.
- `in_ready` out 1: loader accepts a word.
- `in_data` in DATA_W: host word.
- `ACT_d` out DATA_W: ACT SRAM write data.
- `ACT_addr` out ADDR_W: ACT SRAM address.
- `ACT_cen` out 1: ACT chip enable, active-low.
- `ACT_wen` out 1: ACT write enable, active-low.
- `W_d`, `W_addr`, `W_cen`, `W_wen`: the same set of ports for the W SRAM.
- `aw_owner` out 1: 1 = loader drives the SRAM ports; 0 = corelet does (mux select).
- `seq_begin` out 1: one-cycle start pulse to the corelet.
- `seq_done` in 1: completion pulse from the corelet.
- `busy` out 1: high in every state except IDLE.
- `tile_done` out 1: one-cycle pulse when the corelet finishes.
- `timeout_err` out 1: one-cycle pulse when the watchdog expires.

## Operation

- States: IDLE, LOAD_ACT, LOAD_W, START, WAIT_DONE, DONE.
- IDLE: `load_start`=1 → LOAD_ACT, word counter cleared to 0.
- LOAD_ACT: `in_ready`=1. Each handshake (`in_valid & in_ready`) writes `in_data` to ACT address = counter, then counter+1. The handshake at counter = ACT_WORDS-1 → LOAD_W, counter cleared to 0.
- LOAD_W: same behaviour targeting the W SRAM. The handshake at counter = W_WORDS-1 → START.
- START: `seq_begin`=1 for exactly this cycle → WAIT_DONE, watchdog cleared to 0.
- WAIT_DONE: watchdog increments every cycle.
  - `seq_done`=1 → DONE.
  - Else watchdog = TIMEOUT-1 → `timeout_err` pulse, → IDLE.
  - If `seq_done` arrives in the expiry cycle, `seq_done` wins.
- DONE: `tile_done`=1 for one cycle → IDLE.
- `aw_owner` = 0 only in WAIT_DONE and DONE; otherwise 1.
- `in_ready` = 0 outside LOAD_ACT/LOAD_W. Host words in other states are not consumed.
- Inputs ignored outside their state:
  - `load_start` outside IDLE.
  - `seq_done` outside WAIT_DONE.
- A stall (`in_valid`=0) holds state and counter indefinitely; there is no timeout while loading.
- `reset`=0 in any state, including mid-load or mid-WAIT_DONE → IDLE on that edge.
  - Partially written SRAM contents are left as-is.
  - No `seq_begin`, `tile_done` or `timeout_err` is emitted.
- Counters are sized to hold max(ACT_WORDS, W_WORDS)-1 and TIMEOUT-1 and never wrap.

## Timing

- All outputs are registered.
- Reset values:
  - `in_ready` 0, `busy` 0, `aw_owner` 1.
  - `ACT_cen`/`ACT_wen`/`W_cen`/`W_wen` 1.
  - `ACT_addr`/`W_addr`/`ACT_d`/`W_d` 0.
  - `seq_begin` 0, `tile_done` 0, `timeout_err` 0.
- Write latency: a handshake on edge N drives cen=0, wen=0, addr and data during cycle N..N+1, so the SRAM captures the write on edge N+1.
  - Idle write cycles have cen=wen=1; addr and data hold their last values.
  - Only the SRAM of the current phase is ever enabled.
- Throughput: one word per cycle with `in_valid` held high. `load_start` to `seq_begin` takes ACT_WORDS+W_WORDS+1 cycles minimum.
- The final W write is performed during the START cycle, while `aw_owner`=1. The corelet issues its first read no earlier than the cycle after `seq_begin`.
- `busy` rises the cycle after `load_start` is accepted and falls with the return to IDLE.

## Test plan

- Reset: hold `reset`=0 for 3 cycles → every output at its reset value; `in_ready`=0 even with `in_valid`=1.
- Full tile, no stalls: send ACT words 0x1000_0000+i and W words 0x2000_0000+j. Require:
  - ACT[i] and W[j] hold exactly those values.
  - `seq_begin` pulses once, 109 cycles after `load_start`.
  - `seq_done` 20 cycles later → `tile_done` pulse one cycle after it; `busy` then 0.
- Random `in_valid` stalls (~30% duty): same SRAM contents, no duplicate or skipped addresses, cen=1 on every stall cycle.
- Watchdog: never assert `seq_done` → `timeout_err` pulse exactly TIMEOUT cycles after entering WAIT_DONE; no `tile_done`; back in IDLE with `aw_owner`=1.
- Ignored inputs:
  - `load_start` pulses during LOAD_W → no restart.
  - `seq_done` pulses during LOAD_ACT → no effect.
  - `seq_done` coincident with watchdog expiry → `tile_done`, not `timeout_err`.
- Reset mid-load: assert `reset` after 20 ACT words → IDLE next cycle, `in_ready`=0, no `seq_begin`. A new tile then loads cleanly starting at address 0.

Source files
------------

// File: rtl/aw_sram_loader_if.sv
// Host word stream plus the ACT/W SRAM write ports driven by aw_sram_loader.
// master = loader side, slave = host / SRAM-mux side.
interface aw_sram_loader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    logic [DATA_W-1:0] ACT_d;
    logic [ADDR_W-1:0] ACT_addr;
    logic              ACT_cen;
    logic              ACT_wen;

    logic [DATA_W-1:0] W_d;
    logic [ADDR_W-1:0] W_addr;
    logic              W_cen;
    logic              W_wen;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output ACT_d, ACT_addr, ACT_cen, ACT_wen,
        output W_d, W_addr, W_cen, W_wen
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  ACT_d, ACT_addr, ACT_cen, ACT_wen,
        input  W_d, W_addr, W_cen, W_wen
    );
endinterface

// File: rtl/aw_sram_loader.sv
// Streams one tile (activations, then kij-major weights) into the ACT and W
// SRAMs, starts the corelet and waits for its completion under a watchdog.
module aw_sram_loader #(
    parameter int ACT_WORDS = 36,
    parameter int W_WORDS   = 72,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 4095
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic             seq_done,
    output logic             seq_begin,
    output logic             aw_owner,
    output logic             busy,
    output logic             tile_done,
    output logic             timeout_err,
    aw_sram_loader_if.master bus
);
    localparam int MAX_WORDS = (ACT_WORDS > W_WORDS) ? ACT_WORDS : W_WORDS;
    localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]  ACT_LAST  = CNT_W'(ACT_WORDS - 1);
    localparam logic [CNT_W-1:0]  W_LAST    = CNT_W'(W_WORDS - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_ACT  = 3'd1,
        LOAD_W    = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WDOG_W-1:0]  wdog_r;
    logic               xfer_s;

    // in_ready is registered and tracks the load states exactly, so it doubles as the phase gate.
    assign xfer_s = bus.in_valid & bus.in_ready;

    // Control FSM with all outputs registered; write strobes and pulses default inactive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            wdog_r       <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            aw_owner     <= 1'b1;
            seq_begin    <= 1'b0;
            tile_done    <= 1'b0;
            timeout_err  <= 1'b0;
            bus.ACT_cen  <= 1'b1;
            bus.ACT_wen  <= 1'b1;
            bus.ACT_addr <= '0;
            bus.ACT_d    <= '0;
            bus.W_cen    <= 1'b1;
            bus.W_wen    <= 1'b1;
            bus.W_addr   <= '0;
            bus.W_d      <= '0;
        end else begin
            bus.ACT_cen <= 1'b1;
            bus.ACT_wen <= 1'b1;
            bus.W_cen   <= 1'b1;
            bus.W_wen   <= 1'b1;
            seq_begin   <= 1'b0;
            tile_done   <= 1'b0;
            timeout_err <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (load_start) begin
                        state_r      <= LOAD_ACT;
                        cnt_r        <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                    end
                end

                LOAD_ACT: begin
                    if (xfer_s) begin
                        bus.ACT_cen  <= 1'b0;
                        bus.ACT_wen  <= 1'b0;
                        bus.ACT_addr <= ADDR_W'(cnt_r);
                        bus.ACT_d    <= bus.in_data;
                        if (cnt_r == ACT_LAST) begin
                            state_r <= LOAD_W;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r   <= cnt_r + 1'b1;
                        end
                    end else begin
                        state_r <= LOAD_ACT;
                    end
                end

                LOAD_W: begin
                    if (xfer_s) begin
                        bus.W_cen  <= 1'b0;
                        bus.W_wen  <= 1'b0;
                        bus.W_addr <= ADDR_W'(cnt_r);
                        bus.W_d    <= bus.in_data;
                        if (cnt_r == W_LAST) begin
                            // last W write lands during START, while the loader still owns the ports
                            state_r      <= START;
                            bus.in_ready <= 1'b0;
                            seq_begin    <= 1'b1;
                        end else begin
                            cnt_r        <= cnt_r + 1'b1;
                        end
                    end else begin
                        state_r <= LOAD_W;
                    end
                end

                START: begin
                    state_r  <= WAIT_DONE;
                    wdog_r   <= '0;
                    aw_owner <= 1'b0;
                end

                WAIT_DONE: begin
                    if (seq_done) begin
                        state_r   <= DONE;
                        tile_done <= 1'b1;
                    end else if (wdog_r == WDOG_LAST) begin
                        state_r     <= IDLE;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        aw_owner    <= 1'b1;
                    end else begin
                        wdog_r <= wdog_r + 1'b1;
                    end
                end

                DONE: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    aw_owner <= 1'b1;
                end

                default: begin
                    state_r      <= IDLE;
                    bus.in_ready <= 1'b0;
                    busy         <= 1'b0;
                    aw_owner     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aw_sram_loader.sv
// Self-checking bench for aw_sram_loader: vector table, directed corner cases
// and randomized stalled tiles checked against SRAM models and expected word lists.
module tb_aw_sram_loader;
    localparam int ACT_WORDS = 36;
    localparam int W_WORDS   = 72;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT   = 4095;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic load_start = 1'b0;
    logic seq_done = 1'b0;
    logic seq_begin, aw_owner, busy, tile_done, timeout_err;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int begin_cnt = 0, tile_cnt = 0, tmo_cnt = 0, en_viol = 0;
    int exp_begins = 0, exp_tiles = 0, exp_tmo = 0;
    logic hs_prev_r = 1'b0;

    logic [DATA_W-1:0] act_mem [ACT_WORDS];
    logic [DATA_W-1:0] w_mem   [W_WORDS];
    logic [DATA_W-1:0] exp_act [ACT_WORDS];
    logic [DATA_W-1:0] exp_w   [W_WORDS];
    logic [ADDR_W+DATA_W-1:0] act_q [$];
    logic [ADDR_W+DATA_W-1:0] w_q   [$];

    aw_sram_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    aw_sram_loader #(
        .ACT_WORDS(ACT_WORDS), .W_WORDS(W_WORDS), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .seq_done(seq_done),
        .seq_begin(seq_begin), .aw_owner(aw_owner), .busy(busy),
        .tile_done(tile_done), .timeout_err(timeout_err), .bus(bus)
    );

    always #5 clk = ~clk;

    // SRAM models, pulse counters and write-enable sanity monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ACT_cen === 1'b0 && bus.ACT_wen === 1'b0) begin
            if (int'(bus.ACT_addr) < ACT_WORDS) act_mem[int'(bus.ACT_addr)] <= bus.ACT_d;
            act_q.push_back({bus.ACT_addr, bus.ACT_d});
        end
        if (bus.W_cen === 1'b0 && bus.W_wen === 1'b0) begin
            if (int'(bus.W_addr) < W_WORDS) w_mem[int'(bus.W_addr)] <= bus.W_d;
            w_q.push_back({bus.W_addr, bus.W_d});
        end
        if (seq_begin === 1'b1) begin_cnt <= begin_cnt + 1;
        if (tile_done === 1'b1) tile_cnt <= tile_cnt + 1;
        if (timeout_err === 1'b1) tmo_cnt <= tmo_cnt + 1;
        if (cyc > 2 && ((((bus.ACT_cen === 1'b0) || (bus.W_cen === 1'b0)) != hs_prev_r) ||
                        (bus.ACT_cen === 1'b0 && bus.W_cen === 1'b0)))
            en_viol <= en_viol + 1;
        hs_prev_r <= reset & bus.in_valid & bus.in_ready;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Streams nwords from the expected arrays; returns at the negedge after the last accepted word.
    task automatic load_tile(input int stall_pct, input bit noise, input int nwords,
                             output int c0, output bit ok);
        int k;
        int guard;
        @(negedge clk);
        c0 = cyc;
        load_start = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        k = 0;
        guard = 0;
        while (k < nwords && guard < 3000) begin
            bus.in_valid = ($urandom_range(99) >= stall_pct);
            if (bus.in_valid) bus.in_data = (k < ACT_WORDS) ? exp_act[k] : exp_w[k - ACT_WORDS];
            else bus.in_data = $urandom;
            load_start = noise && (k >= ACT_WORDS) && ($urandom_range(3) == 0);
            seq_done = noise && (k < ACT_WORDS) && ($urandom_range(3) == 0);
            if (bus.in_valid && bus.in_ready) k++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        load_start = 1'b0;
        seq_done = 1'b0;
        ok = (k == nwords);
    endtask

    task automatic full_load(input string tag, input int stall_pct, input bit rnd, input bit noise);
        int c0;
        bit ok;
        for (int i = 0; i < ACT_WORDS; i++) exp_act[i] = rnd ? $urandom : 32'h1000_0000 + 32'(i);
        for (int j = 0; j < W_WORDS; j++) exp_w[j] = rnd ? $urandom : 32'h2000_0000 + 32'(j);
        act_q.delete();
        w_q.delete();
        load_tile(stall_pct, noise, ACT_WORDS + W_WORDS, c0, ok);
        check({tag, " load_guard"}, 64'(ok), 64'd1);
        check({tag, " start_cycle"}, {seq_begin, aw_owner, busy, bus.W_cen, bus.W_addr},
              {1'b1, 1'b1, 1'b1, 1'b0, 7'(W_WORDS - 1)});
        if (stall_pct == 0) check({tag, " latency"}, 64'(cyc - c0), 64'(ACT_WORDS + W_WORDS + 1));
        exp_begins++;
    endtask

    task automatic check_mem(input string tag);
        int e;
        e = 0;
        for (int i = 0; i < ACT_WORDS; i++) if (act_mem[i] !== exp_act[i]) e++;
        check({tag, " act_mem"}, 64'(e), 64'd0);
        e = 0;
        for (int j = 0; j < W_WORDS; j++) if (w_mem[j] !== exp_w[j]) e++;
        check({tag, " w_mem"}, 64'(e), 64'd0);
        e = 0;
        if (act_q.size() != ACT_WORDS || w_q.size() != W_WORDS) e = 1000;
        else begin
            for (int i = 0; i < ACT_WORDS; i++) if (act_q[i] !== {7'(i), exp_act[i]}) e++;
            for (int j = 0; j < W_WORDS; j++) if (w_q[j] !== {7'(j), exp_w[j]}) e++;
        end
        check({tag, " write_order"}, 64'(e), 64'd0);
    endtask

    // Called at the START negedge (cycle b); corelet answers delay cycles later.
    task automatic finish_normal(input string tag, input int delay);
        @(negedge clk);
        check({tag, " wait_owner"}, {aw_owner, busy, bus.in_ready}, {1'b0, 1'b1, 1'b0});
        repeat (delay - 1) @(negedge clk);
        seq_done = 1'b1;
        @(negedge clk);
        seq_done = 1'b0;
        check({tag, " tile_done"}, {tile_done, timeout_err, busy, aw_owner}, {1'b1, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        check({tag, " back_idle"}, {tile_done, busy, aw_owner}, {1'b0, 1'b0, 1'b1});
        exp_tiles++;
    endtask

    task automatic finish_watchdog(input string tag, input bit coincide);
        int b;
        bit ev;
        int tcyc;
        logic [3:0] snap;
        b = cyc;
        ev = 1'b0;
        tcyc = 0;
        snap = 4'h0;
        for (int n = 0; n < TIMEOUT + 20 && !ev; n++) begin
            @(negedge clk);
            if (tile_done === 1'b1 || timeout_err === 1'b1) begin
                ev = 1'b1;
                tcyc = cyc;
                snap = {tile_done, timeout_err, busy, aw_owner};
            end
            seq_done = coincide && (cyc == b + TIMEOUT);
        end
        seq_done = 1'b0;
        check({tag, " event_seen"}, 64'(ev), 64'd1);
        check({tag, " event_cycle"}, 64'(tcyc - b), 64'(TIMEOUT + 1));
        if (coincide) begin
            check({tag, " flags"}, snap, {1'b1, 1'b0, 1'b1, 1'b0});
            exp_tiles++;
        end else begin
            check({tag, " flags"}, snap, {1'b0, 1'b1, 1'b0, 1'b1});
            exp_tmo++;
        end
        @(negedge clk);
        check({tag, " idle_after"}, {busy, aw_owner, bus.in_ready, tile_done, timeout_err},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    typedef struct {
        logic        rst;
        logic        ls;
        logic        vld;
        logic [31:0] data;
        logic        sd;
        logic        e_rdy;
        logic        e_busy;
        logic        e_own;
        logic        e_acen;
        logic        e_awen;
        logic [6:0]  e_addr;
        logic [31:0] e_d;
    } vec_t;

    initial begin
        vec_t vecs [9];
        int   c0;
        bit   ok;
        int   bc;

        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        //           rst   ls    vld   data          sd    rdy   busy  own   acen  awen  addr   d
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'hA0A0_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 32'hA0A0_0000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'd0, 32'hA0A0_0000};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'hA0A0_0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 32'hA0A0_0001};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'hA0A0_0002, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd2, 32'hA0A0_0002};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 32'hA0A0_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd0, 32'h0};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            load_start = vecs[i].ls;
            bus.in_valid = vecs[i].vld;
            bus.in_data = vecs[i].data;
            seq_done = vecs[i].sd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {bus.in_ready, busy, aw_owner, bus.ACT_cen, bus.ACT_wen, bus.W_cen, bus.W_wen,
                   seq_begin, tile_done, timeout_err, bus.ACT_addr, bus.ACT_d},
                  {vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_own, vecs[i].e_acen, vecs[i].e_awen,
                   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, vecs[i].e_addr, vecs[i].e_d});
        end
        @(negedge clk);
        reset = 1'b1;
        load_start = 1'b0;
        seq_done = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);

        full_load("plain", 0, 1'b0, 1'b0);
        finish_normal("plain", 20);
        check_mem("plain");

        for (int t = 0; t < 3; t++) begin
            full_load($sformatf("stall%0d", t), 30, 1'b1, 1'b1);
            finish_normal($sformatf("stall%0d", t), int'($urandom_range(30, 1)));
            check_mem($sformatf("stall%0d", t));
        end

        full_load("wdog", 0, 1'b1, 1'b0);
        finish_watchdog("wdog", 1'b0);
        check_mem("wdog");

        full_load("coinc", 10, 1'b1, 1'b0);
        finish_watchdog("coinc", 1'b1);

        for (int i = 0; i < ACT_WORDS; i++) exp_act[i] = $urandom;
        act_q.delete();
        w_q.delete();
        bc = begin_cnt;
        load_tile(0, 1'b0, 20, c0, ok);
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = $urandom;
        @(negedge clk);
        check("midreset state", {bus.in_ready, busy, aw_owner, bus.ACT_cen, bus.W_cen},
              {1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        reset = 1'b1;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        check("midreset writes", 64'(act_q.size() + w_q.size()), 64'd20);
        check("midreset no_begin", 64'(begin_cnt - bc), 64'd0);

        full_load("reload", 0, 1'b1, 1'b0);
        finish_normal("reload", 5);
        check_mem("reload");

        repeat (3) @(negedge clk);
        check("seq_begin count", 64'(begin_cnt), 64'(exp_begins));
        check("tile_done count", 64'(tile_cnt), 64'(exp_tiles));
        check("timeout_err count", 64'(tmo_cnt), 64'(exp_tmo));
        check("enable violations", 64'(en_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "time limit");
    end
endmodule
